// File: rtl/issue_pair_buffer_pkg.sv
// ============================================================================
// Module   : issue_pair_buffer_pkg
// Purpose  : Shared opcodes, NOP encoding and defaults for the issue buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package issue_pair_buffer_pkg;

  localparam int DEPTH_DEFAULT = 4;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [31:0] NOP_INST = 32'h00000013;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } ipb_entry_t;

endpackage

`default_nettype wire

// File: rtl/issue_pair_buffer_pre_decode.sv
// ============================================================================
// Module   : pre_decode
// Purpose  : Extracts register fields and pairing-relevant classes of an inst.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pre_decode
  import issue_pair_buffer_pkg::*;
(
  input  logic [31:0] inst,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic        writes_rd,
  output logic        reads_rs1,
  output logic        reads_rs2,
  output logic        is_ctrl,
  output logic        is_mem
);

  logic [6:0] w_opc;
  logic       w_unused_bits;

  assign w_opc         = inst[6:0];
  assign rd            = inst[11:7];
  assign rs1           = inst[19:15];
  assign rs2           = inst[24:20];
  assign w_unused_bits = ^{inst[31:25], inst[14:12]};

  // Store/branch keep immediate bits in the rd field, so rd is only live here.
  assign writes_rd = (w_opc == OPC_LUI)  || (w_opc == OPC_AUIPC) ||
                     (w_opc == OPC_JAL)  || (w_opc == OPC_JALR)  ||
                     (w_opc == OPC_OP)   || (w_opc == OPC_OP_IMM) ||
                     (w_opc == OPC_LOAD);

  assign reads_rs1 = (w_opc == OPC_JALR) || (w_opc == OPC_BRANCH) ||
                     (w_opc == OPC_LOAD) || (w_opc == OPC_STORE)  ||
                     (w_opc == OPC_OP)   || (w_opc == OPC_OP_IMM);

  assign reads_rs2 = (w_opc == OPC_BRANCH) || (w_opc == OPC_STORE) ||
                     (w_opc == OPC_OP);

  assign is_ctrl = (w_opc == OPC_BRANCH) || (w_opc == OPC_JAL) ||
                   (w_opc == OPC_JALR);

  assign is_mem  = (w_opc == OPC_LOAD) || (w_opc == OPC_STORE);

endmodule

`default_nettype wire

// File: rtl/issue_pair_buffer.sv
// ============================================================================
// Module   : issue_pair_buffer
// Purpose  : Circular instruction queue between IF and dual-issue ID; decides
//            whether slot1 issues alongside slot0. Optional counters under
//            ISSUE_PAIR_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module issue_pair_buffer
  import issue_pair_buffer_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_valid0,
  input  logic        fetch_valid1,
  input  logic [31:0] fetch_pc,
  input  logic [31:0] fetch_inst0,
  input  logic [31:0] fetch_inst1,
  output logic        fetch_ready,
  input  logic        ID_stall,
  input  logic        IF_flush,
  output logic        slot0_valid,
  output logic [31:0] slot0_inst,
  output logic [31:0] slot0_pc,
  output logic [31:0] slot1_inst,
  output logic [31:0] slot1_pc,
`ifdef ISSUE_PAIR_STATS_EN
  output logic [31:0] stat_dual_cnt,
  output logic [31:0] stat_single_cnt,
  output logic [31:0] stat_stall_cnt,
`endif
  output logic        two_issue
);

  localparam int CNT_W = PTR_W + 1;

  ipb_entry_t       r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic [PTR_W-1:0] w_head1;
  logic [PTR_W-1:0] w_tail1;
  logic             w_has0;
  logic             w_has1;
  ipb_entry_t       w_e0;
  ipb_entry_t       w_e1;
  logic [1:0]       w_push;
  logic [1:0]       w_pop;

  assign w_head1 = r_head + PTR_W'(1);
  assign w_tail1 = r_tail + PTR_W'(1);
  assign w_has0  = (r_count != '0);
  assign w_has1  = (r_count >= CNT_W'(2));

  // Absent slots read as zero rather than stale storage.
  assign w_e0 = w_has0 ? r_mem[r_head]  : '0;
  assign w_e1 = w_has1 ? r_mem[w_head1] : '0;

  assign slot0_valid = w_has0;
  assign slot0_inst  = w_e0.inst;
  assign slot0_pc    = w_e0.pc;
  assign slot1_inst  = w_e1.inst;
  assign slot1_pc    = w_e1.pc;

  assign fetch_ready = (r_count <= CNT_W'(DEPTH - 2));

  logic [4:0] w_rd0, w_rs1_0, w_rs2_0, w_rd1, w_rs1_1, w_rs2_1;
  logic       w_wr0, w_rd_rs1_0, w_rd_rs2_0, w_ctrl0, w_mem0;
  logic       w_wr1, w_rd_rs1_1, w_rd_rs2_1, w_ctrl1, w_mem1;
  logic       w_unused_slot;

  pre_decode u_dec0 (
    .inst      (w_e0.inst),
    .rd        (w_rd0),
    .rs1       (w_rs1_0),
    .rs2       (w_rs2_0),
    .writes_rd (w_wr0),
    .reads_rs1 (w_rd_rs1_0),
    .reads_rs2 (w_rd_rs2_0),
    .is_ctrl   (w_ctrl0),
    .is_mem    (w_mem0)
  );

  pre_decode u_dec1 (
    .inst      (w_e1.inst),
    .rd        (w_rd1),
    .rs1       (w_rs1_1),
    .rs2       (w_rs2_1),
    .writes_rd (w_wr1),
    .reads_rs1 (w_rd_rs1_1),
    .reads_rs2 (w_rd_rs2_1),
    .is_ctrl   (w_ctrl1),
    .is_mem    (w_mem1)
  );

  assign w_unused_slot = ^{w_rs1_0, w_rs2_0, w_rd_rs1_0, w_rd_rs2_0,
                           w_rd1, w_wr1, w_ctrl1};

  logic w_raw;
  assign w_raw = w_wr0 && (w_rd0 != 5'd0) &&
                 ((w_rd_rs1_1 && (w_rs1_1 == w_rd0)) ||
                  (w_rd_rs2_1 && (w_rs2_1 == w_rd0)));

  // Driven purely by queue contents and ID controls; fetch never bypasses.
  assign two_issue = w_has1 && !ID_stall && !IF_flush && !w_ctrl0 &&
                     !(w_mem0 && w_mem1) && !w_raw;

  always_comb begin
    w_pop = 2'd0;
    if (!ID_stall && w_has0)
      w_pop = two_issue ? 2'd2 : 2'd1;
  end

  always_comb begin
    w_push = 2'd0;
    if (fetch_ready && fetch_valid0)
      w_push = fetch_valid1 ? 2'd2 : 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst || IF_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PTR_W'(w_pop);
      r_tail  <= r_tail + PTR_W'(w_push);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // Storage needs no reset: the count masks every stale entry.
  always_ff @(posedge clk) begin
    if (!rst && !IF_flush) begin
      if (w_push != 2'd0)
        r_mem[r_tail] <= '{inst: fetch_inst0, pc: fetch_pc};
      if (w_push == 2'd2)
        r_mem[w_tail1] <= '{inst: fetch_inst1, pc: fetch_pc + 32'd4};
    end
  end

`ifdef ISSUE_PAIR_STATS_EN
  logic [31:0] r_dual_cnt;
  logic [31:0] r_single_cnt;
  logic [31:0] r_stall_cnt;

  // A flush cycle discards slot0, so it is not counted as an issue or stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dual_cnt   <= '0;
      r_single_cnt <= '0;
      r_stall_cnt  <= '0;
    end else if (!IF_flush) begin
      if (two_issue)
        r_dual_cnt <= r_dual_cnt + 32'd1;
      if (w_pop == 2'd1)
        r_single_cnt <= r_single_cnt + 32'd1;
      if (w_has0 && ID_stall)
        r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stat_dual_cnt   = r_dual_cnt;
  assign stat_single_cnt = r_single_cnt;
  assign stat_stall_cnt  = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_issue_pair_buffer.sv
// ============================================================================
// Module   : tb_issue_pair_buffer
// Purpose  : Directed plus random stimulus against a queue-based model of the
//            issue buffer. Counter checks active under ISSUE_PAIR_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_issue_pair_buffer;

  localparam int DEPTH = 4;

  localparam logic [6:0] C_BRANCH = 7'b1100011;
  localparam logic [6:0] C_JAL    = 7'b1101111;
  localparam logic [6:0] C_JALR   = 7'b1100111;
  localparam logic [6:0] C_LOAD   = 7'b0000011;
  localparam logic [6:0] C_STORE  = 7'b0100011;
  localparam logic [6:0] C_LUI    = 7'b0110111;
  localparam logic [6:0] C_AUIPC  = 7'b0010111;
  localparam logic [6:0] C_OP     = 7'b0110011;
  localparam logic [6:0] C_OP_IMM = 7'b0010011;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_valid0 = 1'b0, fetch_valid1 = 1'b0;
  logic [31:0] fetch_pc = '0, fetch_inst0 = '0, fetch_inst1 = '0;
  logic        ID_stall = 1'b0, IF_flush = 1'b0;
  logic        fetch_ready, slot0_valid, two_issue;
  logic [31:0] slot0_inst, slot0_pc, slot1_inst, slot1_pc;
`ifdef ISSUE_PAIR_STATS_EN
  logic [31:0] stat_dual_cnt, stat_single_cnt, stat_stall_cnt;
  int unsigned m_dual = 0, m_single = 0, m_stall = 0;
`endif

  issue_pair_buffer #(.DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .fetch_valid0    (fetch_valid0),
    .fetch_valid1    (fetch_valid1),
    .fetch_pc        (fetch_pc),
    .fetch_inst0     (fetch_inst0),
    .fetch_inst1     (fetch_inst1),
    .fetch_ready     (fetch_ready),
    .ID_stall        (ID_stall),
    .IF_flush        (IF_flush),
    .slot0_valid     (slot0_valid),
    .slot0_inst      (slot0_inst),
    .slot0_pc        (slot0_pc),
    .slot1_inst      (slot1_inst),
    .slot1_pc        (slot1_pc),
`ifdef ISSUE_PAIR_STATS_EN
    .stat_dual_cnt   (stat_dual_cnt),
    .stat_single_cnt (stat_single_cnt),
    .stat_stall_cnt  (stat_stall_cnt),
`endif
    .two_issue       (two_issue)
  );

  always #5 clk = ~clk;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  logic [63:0] mq[$];  // {inst, pc}, head at index 0

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic logic [31:0] mk(input logic [6:0] opc, input int rd, input int rs1, input int rs2);
    mk = {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), opc};
  endfunction

  // Pairing rules stated directly in terms of instruction classes.
  function automatic bit can_pair(input logic [31:0] a, input logic [31:0] b);
    logic [6:0] oa, ob;
    bit a_wr, b_r1, b_r2, hazard;
    oa = a[6:0];
    ob = b[6:0];
    if (oa inside {C_BRANCH, C_JAL, C_JALR}) return 0;
    if ((oa inside {C_LOAD, C_STORE}) && (ob inside {C_LOAD, C_STORE})) return 0;
    a_wr = oa inside {C_LUI, C_AUIPC, C_JAL, C_JALR, C_OP, C_OP_IMM, C_LOAD};
    b_r1 = ob inside {C_JALR, C_BRANCH, C_LOAD, C_STORE, C_OP, C_OP_IMM};
    b_r2 = ob inside {C_BRANCH, C_STORE, C_OP};
    hazard = a_wr && (a[11:7] != 0) &&
             ((b_r1 && b[19:15] == a[11:7]) || (b_r2 && b[24:20] == a[11:7]));
    return !hazard;
  endfunction

  task automatic step(input logic r, input logic v0, input logic v1, input logic [31:0] pc,
                      input logic [31:0] i0, input logic [31:0] i1,
                      input logic st, input logic fl);
    int n, npop;
    logic [63:0] e0, e1;
    bit exp_ready, exp_two;
    @(negedge clk);
    rst = r; fetch_valid0 = v0; fetch_valid1 = v1; fetch_pc = pc;
    fetch_inst0 = i0; fetch_inst1 = i1; ID_stall = st; IF_flush = fl;
    #1;
    n = mq.size();
    e0 = (n >= 1) ? mq[0] : 64'd0;
    e1 = (n >= 2) ? mq[1] : 64'd0;
    exp_ready = (DEPTH - n) >= 2;
    exp_two = (n >= 2) && !st && !fl && can_pair(e0[63:32], e1[63:32]);
    check_eq("fetch_ready", 64'(fetch_ready), 64'(exp_ready));
    check_eq("slot0_valid", 64'(slot0_valid), 64'(n >= 1));
    check_eq("slot0",       {slot0_inst, slot0_pc}, e0);
    check_eq("slot1",       {slot1_inst, slot1_pc}, e1);
    check_eq("two_issue",   64'(two_issue), 64'(exp_two));
`ifdef ISSUE_PAIR_STATS_EN
    check_eq("stat_dual",   64'(stat_dual_cnt),   64'(m_dual));
    check_eq("stat_single", 64'(stat_single_cnt), 64'(m_single));
    check_eq("stat_stall",  64'(stat_stall_cnt),  64'(m_stall));
`endif
    npop = (st || n == 0) ? 0 : (exp_two ? 2 : 1);
    if (r) begin
      mq.delete();
`ifdef ISSUE_PAIR_STATS_EN
      m_dual = 0; m_single = 0; m_stall = 0;
`endif
    end else if (fl) begin
      mq.delete();
    end else begin
`ifdef ISSUE_PAIR_STATS_EN
      if (npop == 2) m_dual++;
      if (npop == 1) m_single++;
      if (n >= 1 && st) m_stall++;
`endif
      for (int k = 0; k < npop; k++) void'(mq.pop_front());
      if (exp_ready && v0) begin
        mq.push_back({i0, pc});
        if (v1) mq.push_back({i1, pc + 32'd4});
      end
    end
  endtask

  task automatic idle(input logic st);
    step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, st, 1'b0);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0] opcs [9];
    logic [31:0] w;
    opcs = '{C_BRANCH, C_JAL, C_JALR, C_LOAD, C_STORE, C_LUI, C_AUIPC, C_OP, C_OP_IMM};
    w = mk(opcs[$urandom_range(0, 8)], $urandom_range(0, 7), $urandom_range(0, 7),
           $urandom_range(0, 7));
    w[31:25] = 7'($urandom);
    w[14:12] = 3'($urandom);
    return w;
  endfunction

  initial begin
    step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 32'h100, 32'h00100093, 32'h00200113, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);
    // RAW pair issues one at a time
    step(1'b0, 1'b1, 1'b1, 32'h200, 32'h00300293, 32'h00528333, 1'b0, 1'b0);
    idle(1'b0); idle(1'b0); idle(1'b0);
    // Control in slot0, mem+mem, then mem+alu
    step(1'b0, 1'b1, 1'b1, 32'h300, mk(C_BRANCH, 8, 1, 2), mk(C_OP, 7, 8, 9), 1'b0, 1'b0);
    idle(1'b0); idle(1'b0);
    step(1'b0, 1'b1, 1'b1, 32'h400, mk(C_LOAD, 3, 1, 0), mk(C_STORE, 4, 1, 4), 1'b0, 1'b0);
    idle(1'b0); idle(1'b0);
    step(1'b0, 1'b1, 1'b1, 32'h500, mk(C_LOAD, 3, 1, 0), mk(C_OP, 7, 8, 9), 1'b0, 1'b0);
    idle(1'b0); idle(1'b0);
    // Fill under stall, refused push while full, then drain across the wrap
    step(1'b0, 1'b1, 1'b1, 32'h600, mk(C_OP_IMM, 1, 0, 1), mk(C_OP_IMM, 2, 0, 2), 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 32'h608, mk(C_OP_IMM, 3, 0, 1), mk(C_OP_IMM, 4, 0, 2), 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 32'h610, mk(C_OP_IMM, 5, 0, 1), mk(C_OP_IMM, 6, 0, 2), 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b0); idle(1'b0); idle(1'b0);
    // Flush with count=3 plus a same-cycle push, then flush under stall
    step(1'b0, 1'b1, 1'b1, 32'h700, mk(C_OP, 1, 2, 3), mk(C_OP, 4, 5, 6), 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 32'h708, mk(C_OP, 7, 2, 3), 32'd0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 32'h800, mk(C_OP, 1, 2, 3), mk(C_OP, 4, 5, 6), 1'b0, 1'b1);
    idle(1'b0);
    step(1'b0, 1'b1, 1'b1, 32'h900, mk(C_OP, 1, 2, 3), mk(C_OP, 4, 5, 6), 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b1);
    idle(1'b0);
    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      logic v0;
      v0 = ($urandom_range(0, 9) < 7);
      step(($urandom_range(0, 199) == 0), v0, v0 && $urandom_range(0, 1) == 1,
           32'($urandom) & ~32'd3, rand_inst(), rand_inst(),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0));
    end
    // Mid-operation reset returns outputs to reset values
    step(1'b0, 1'b1, 1'b1, 32'hA00, mk(C_OP, 1, 2, 3), mk(C_OP, 4, 5, 6), 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    idle(1'b0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/issue_pair_buffer.md
Name: issue_pair_buffer

Overview:
- Instruction buffer between IF and the dual-issue ID stage.
- Accepts up to two fetched instructions per cycle and holds them in a circular queue.
- Each cycle it presents slot0/slot1 to the decoders and produces `two_issue`, which tells the slot-1 IF/ID pipeline register whether to capture or bubble.
- Honours `ID_stall` (hold) and `IF_flush` (discard); it is the producer side of the `two_issue` / `ID_stall` / `IF_flush` contract.

Parameters:
- DEPTH, 4: queue entries; power of two, at least 4.
- PTR_W, $clog2(DEPTH): pointer width; count is PTR_W+1 bits.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- fetch_valid0  in  1  fetch_inst0 valid
- fetch_valid1  in  1  fetch_inst1 valid; only legal with fetch_valid0=1
- fetch_pc  in  32  PC of fetch_inst0; fetch_inst1 is at fetch_pc+4
- fetch_inst0  in  32  instruction word 0
- fetch_inst1  in  32  instruction word 1
- fetch_ready  out  1  free entries >= 2
- ID_stall  in  1  ID cannot accept; no pop
- IF_flush  in  1  discard all queued instructions
- slot0_valid  out  1  slot0 holds an instruction
- slot0_inst  out  32  head instruction
- slot0_pc  out  32  head PC
- slot1_inst  out  32  head+1 instruction
- slot1_pc  out  32  head+1 PC
- two_issue  out  1  slot1 is issued together with slot0 this cycle

Behaviour:
- Reset: head=tail=count=0; fetch_ready=1; slot0_valid=0; two_issue=0; all slot inst/pc outputs = 0.
- Push: accepted only when fetch_ready=1.
  - fetch_valid0 alone writes 1 entry.
  - Both valids write 2 entries: inst0 at tail, inst1 at tail+1.
  - Each entry stores {inst, pc}.
- Pops per cycle:
  - 0 if ID_stall=1, or count=0.
  - 2 if two_issue=1.
  - 1 otherwise.
- Slot outputs are combinational from queue storage.
  - slot0_valid = (count>=1).
  - Any slot whose entry is absent outputs inst=0 and pc=0.
- two_issue=1 only when all of the following hold:
  - count>=2 and ID_stall=0 and IF_flush=0;
  - slot0 is not a control instruction (opcode BRANCH 1100011, JAL 1101111, JALR 1100111);
  - not both slots are memory ops (LOAD 0000011 / STORE 0100011; single data port);
  - no RAW hazard: slot0 rd!=0 while writing, and slot1 reads that register via rs1 or rs2.
  - slot1 may itself be a branch.
- two_issue depends only on queue contents and ID_stall/IF_flush, never on the fetch inputs, so it has no same-cycle bypass from fetch.
- Latency: an instruction pushed in cycle N is visible on the slot outputs in cycle N+1. An empty queue does not bypass.
- Simultaneous push and pop: count_next = count + pushed - popped. fetch_ready is computed from the registered count, so push is judged conservatively.
- Pointer wrap: head and tail wrap modulo DEPTH. The pair at head and head+1 may straddle the wrap.
- IF_flush:
  - Highest priority after rst.
  - Next cycle head=tail=count=0, and the same-cycle push is dropped.
  - While IF_flush=1, two_issue=0.
- ID_stall with IF_flush: flush wins.
- Reset mid-operation: contents discarded on the next edge; outputs return to reset values.

Optional Feature:
- Macro: ISSUE_PAIR_STATS_EN.
- When defined, adds three outputs:
  - stat_dual_cnt (32): cycles with two_issue=1.
  - stat_single_cnt (32): cycles with one pop.
  - stat_stall_cnt (32): cycles with count>=1 and ID_stall=1.
- Counters are cleared by rst, not by IF_flush, and wrap at 2^32.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Shared package holds the opcode constants (OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LOAD, OPC_STORE, OPC_LUI, OPC_AUIPC, OPC_OP, OPC_OP_IMM), the NOP encoding 32'h00000013, and the DEPTH default.
- One natural combinational sub-module, `pre_decode`:
  - Input: inst.
  - Outputs: rd, rs1, rs2, writes_rd, reads_rs1, reads_rs2, is_ctrl, is_mem.
  - Instantiated twice, once per slot, and feeds the pairing logic.

Test Plan:
- Reset, then push pair (pc=0x100, `addi x1,x0,1`; `addi x2,x0,2`) -> next cycle slot0_pc=0x100, slot1_pc=0x104, two_issue=1; count returns to 0.
- RAW: push `addi x5,x0,3` then `add x6,x5,x5` -> two_issue=0 for one cycle, then second instruction issues alone from slot0.
- Control/mem: slot0 `beq x1,x2,8` -> two_issue=0. Then `lw x3,0(x1)` + `sw x4,4(x1)` -> two_issue=0. Then `lw` + `add x7,x8,x9` -> two_issue=1.
- Fill with ID_stall=1 held: 4 entries -> fetch_ready=0 and contents unchanged. Release stall -> pops 2/cycle; head wraps 3->0 with correct pc order.
- IF_flush with count=3 plus simultaneous fetch push -> next cycle count=0, slot0_valid=0, pushed instructions absent. ID_stall=1 with IF_flush=1 also flushes.
- With ISSUE_PAIR_STATS_EN: 3 dual, 2 single and 4 stall cycles -> counters read 3, 2 and 4; an intervening flush leaves them unchanged; rst clears them to 0.
